pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clock, input, 1: system clock; all state updates on the rising edge.
REQ-002 SHALL have port nreset, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have ports id_rs1, id_rs2, input, 5 each: source register indices of the instruction in ID.
REQ-004 SHALL have ports id_uses_rs1, id_uses_rs2, input, 1 each: ID instruction reads that source.
REQ-005 SHALL have ports ex_is_load (input, 1) and ex_rd (input, 5): EX instruction is a load, and its destination index.
REQ-006 SHALL have port branch_taken, input, 1: EX resolved a taken branch or jump this cycle.
REQ-007 SHALL have ports mem_req (input, 1) and mem_ready (input, 1): data-memory access in MEM, and memory completion.
REQ-008 SHALL have port pc_en, output, 1: PC may advance.
REQ-009 SHALL have ports if_id_stall (output, 1) and if_id_flush (output, 1): hold or clear the IF/ID register.
REQ-010 SHALL have port id_ex_bubble, output, 1: insert a NOP into ID/EX.
REQ-011 SHALL have port take_branch_addr, output, 1: fetch selects the branch target this cycle.
REQ-012 SHALL have port stall_cycles, output, 16: performance counter of stalled cycles.

Function
REQ-013 SHALL hold a registered state in {RUN, MEM_WAIT, FLUSH}; outputs SHALL be combinational from the state and the current inputs.
REQ-014 SHALL detect load-use when ex_is_load=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)); register 0 SHALL never cause a hazard.
REQ-015 SHALL apply this priority in every cycle: branch_taken > memory wait > load-use.
REQ-016 RUN, branch_taken=1: take_branch_addr=1, if_id_flush=1, id_ex_bubble=1, pc_en=1; next state = FLUSH.
REQ-017 RUN, mem_req=1 and mem_ready=0: pc_en=0, if_id_stall=1, id_ex_bubble=0; next state = MEM_WAIT.
REQ-018 RUN, load-use only: pc_en=0, if_id_stall=1, id_ex_bubble=1 for exactly one cycle; the state SHALL remain RUN.
REQ-019 RUN, no event: pc_en=1; all other control outputs = 0.
REQ-020 FLUSH: if_id_flush=1, id_ex_bubble=1, pc_en=1 for one cycle; next state = RUN. A branch_taken arriving in FLUSH SHALL be ignored, because its EX slot holds a bubble.
REQ-021 MEM_WAIT: pc_en=0 and if_id_stall=1 while mem_ready=0; in the cycle mem_ready=1, pc_en=1 and stalls deassert; next state = RUN.
REQ-022 If branch_taken=1 while in MEM_WAIT, it SHALL be latched in a branch_pending flag. On exit, take_branch_addr=1 and if_id_flush=1 SHALL be asserted, next state = FLUSH, and branch_pending SHALL clear.
REQ-023 if_id_stall and if_id_flush SHALL never both be 1; flush wins.
REQ-024 stall_cycles SHALL increment by 1 in each cycle where pc_en=0, and SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-025 SHALL, on nreset=0, immediately clear state to RUN, branch_pending=0, and stall_cycles=0, independent of clock.
REQ-026 During reset, outputs SHALL be: pc_en=0, if_id_stall=0, if_id_flush=1, id_ex_bubble=1, take_branch_addr=0.
REQ-027 SHALL abandon any in-progress MEM_WAIT or FLUSH on reset mid-operation; the first cycle after deassertion SHALL behave as RUN.

Structure
REQ-028 SHALL take the state encoding (RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2), the register-index width 5, and the counter width 16 from the shared pipeline package.
REQ-029 SHALL place the load-use comparator in one sub-module, hazard_detect (purely combinational); the remaining logic SHALL be flat.

Verification
REQ-030 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_en=0, if_id_stall=1, id_ex_bubble=1, then pc_en=1; stall_cycles=1.
REQ-031 Register zero: same stimulus as REQ-030 with ex_rd=0, id_rs1=0 -> no stall; pc_en stays 1.
REQ-032 Branch: branch_taken=1 in RUN -> take_branch_addr=1 and flush in that cycle, one FLUSH cycle, then RUN; pc_en never 0.
REQ-033 Memory wait with branch: mem_req=1, mem_ready=0 for 3 cycles, branch_taken=1 in wait cycle 2, then mem_ready=1 -> 3 stalled cycles, exit cycle asserts take_branch_addr=1 and flush, then FLUSH; stall_cycles=3.
REQ-034 Simultaneous events: branch_taken=1 and load-use in the same RUN cycle -> flush only, if_id_stall=0.
REQ-035 Reset and saturation: nreset=0 mid-MEM_WAIT -> asynchronous return to RUN with counter 0; force 70000 stalled cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: control state encoding and datapath widths
// used by the hazard controller and its load-use comparator.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID source that depends on a load still in EX.
// Register zero is hardwired and can never create a dependency.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves branch flushes, data-memory waits and
// load-use stalls (in that priority) and counts cycles where the PC is held.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             nreset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             take_branch_addr,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e             state_q, state_d;
  logic               branch_pending_q, branch_pending_d;
  logic [CNT_W-1:0]   stall_cycles_q;
  logic               load_use;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q          <= RUN;
      branch_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      branch_pending_q <= branch_pending_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    branch_pending_d = branch_pending_q;
    pc_en            = 1'b1;
    if_id_stall      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    take_branch_addr = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          take_branch_addr = 1'b1;
          if_id_flush      = 1'b1;
          id_ex_bubble     = 1'b1;
          state_d          = FLUSH;
        end else if (mem_req && !mem_ready) begin
          pc_en       = 1'b0;
          if_id_stall = 1'b1;
          state_d     = MEM_WAIT;
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end

      FLUSH: begin
        // A branch seen here comes from the bubble we just inserted: ignore it.
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end

      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_en       = 1'b0;
          if_id_stall = 1'b1;
          if (branch_taken) begin
            branch_pending_d = 1'b1;
          end
        end else if (branch_pending_q || branch_taken) begin
          take_branch_addr = 1'b1;
          if_id_flush      = 1'b1;
          id_ex_bubble     = 1'b1;
          branch_pending_d = 1'b0;
          state_d          = FLUSH;
        end else begin
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    // Reset forces a safe pipeline: nothing fetched, front end cleared.
    if (!nreset) begin
      pc_en            = 1'b0;
      if_id_stall      = 1'b0;
      if_id_flush      = 1'b1;
      id_ex_bubble     = 1'b1;
      take_branch_addr = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      stall_cycles_q <= '0;
    end else if (!pc_en && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; control outputs are checked as the
// vector {pc_en, if_id_stall, if_id_flush, id_ex_bubble, take_branch_addr}.
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        nreset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load;
  logic        branch_taken, mem_req, mem_ready;
  logic        pc_en, if_id_stall, if_id_flush, id_ex_bubble, take_branch_addr;
  logic [15:0] stall_cycles;
  logic [4:0]  ctl;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Expected control vectors
  localparam logic [4:0] V_RUN   = 5'b10000;
  localparam logic [4:0] V_LU    = 5'b01010;
  localparam logic [4:0] V_MEM   = 5'b01000;
  localparam logic [4:0] V_BR    = 5'b10111;
  localparam logic [4:0] V_FLUSH = 5'b10110;
  localparam logic [4:0] V_RST   = 5'b00110;

  pipeline_hazard_ctrl dut (
    .clock            (clock),
    .nreset           (nreset),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_is_load       (ex_is_load),
    .ex_rd            (ex_rd),
    .branch_taken     (branch_taken),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .pc_en            (pc_en),
    .if_id_stall      (if_id_stall),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .take_branch_addr (take_branch_addr),
    .stall_cycles     (stall_cycles)
  );

  always #5 clock = ~clock;

  assign ctl = {pc_en, if_id_stall, if_id_flush, id_ex_bubble, take_branch_addr};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance to just after the next rising edge, then sample at the falling edge.
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  initial begin
    idle();
    nreset = 1'b1;
    #1 nreset = 1'b0;
    #1;
    chk("reset_ctl", 16'(ctl), 16'(V_RST));
    chk("reset_cnt", stall_cycles, 16'd0);
    smp();
    nreset = 1'b1;

    // Plain RUN
    nxt(); smp();
    chk("run_idle", 16'(ctl), 16'(V_RUN));

    // Load-use on rs1
    nxt();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    smp();
    chk("lu_rs1", 16'(ctl), 16'(V_LU));
    nxt(); idle(); smp();
    chk("lu_after", 16'(ctl), 16'(V_RUN));
    chk("lu_cnt", stall_cycles, 16'd1);

    // Register zero never hazards
    nxt();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    smp();
    chk("r0_nostall", 16'(ctl), 16'(V_RUN));

    // Matching index but source unused
    nxt();
    ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
    smp();
    chk("unused_rs1", 16'(ctl), 16'(V_RUN));

    // Matching rs2 but EX not a load
    nxt();
    ex_is_load = 1'b0; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_uses_rs1 = 1'b0;
    smp();
    chk("not_load", 16'(ctl), 16'(V_RUN));

    // Load-use on rs2
    nxt();
    ex_is_load = 1'b1;
    smp();
    chk("lu_rs2", 16'(ctl), 16'(V_LU));
    nxt(); idle(); smp();
    chk("lu_rs2_cnt", stall_cycles, 16'd2);

    // Branch in RUN, then a branch in FLUSH is ignored
    nxt(); branch_taken = 1'b1; smp();
    chk("br_run", 16'(ctl), 16'(V_BR));
    nxt(); smp();
    chk("br_flush_ign", 16'(ctl), 16'(V_FLUSH));
    nxt(); idle(); smp();
    chk("br_back_run", 16'(ctl), 16'(V_RUN));
    chk("br_cnt", stall_cycles, 16'd2);

    // Branch beats load-use
    nxt();
    branch_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    smp();
    chk("br_vs_lu", 16'(ctl), 16'(V_BR));
    nxt(); idle(); smp();
    chk("br_vs_lu_flush", 16'(ctl), 16'(V_FLUSH));

    // Branch beats memory wait
    nxt(); branch_taken = 1'b1; mem_req = 1'b1; smp();
    chk("br_vs_mem", 16'(ctl), 16'(V_BR));
    nxt(); idle(); smp();
    chk("br_vs_mem_flush", 16'(ctl), 16'(V_FLUSH));

    // Restart counter for the memory-wait scenario
    nxt(); #1 nreset = 1'b0; #1 nreset = 1'b1;
    chk("rst2_cnt", stall_cycles, 16'd0);

    // Memory wait with a branch latched in wait cycle 2
    nxt(); mem_req = 1'b1; mem_ready = 1'b0; smp();
    chk("mw_c1", 16'(ctl), 16'(V_MEM));
    nxt(); branch_taken = 1'b1; smp();
    chk("mw_c2", 16'(ctl), 16'(V_MEM));
    nxt(); branch_taken = 1'b0; smp();
    chk("mw_c3", 16'(ctl), 16'(V_MEM));
    nxt(); mem_ready = 1'b1; smp();
    chk("mw_exit_pc", 16'(pc_en), 16'd1);
    chk("mw_exit_stall", 16'(if_id_stall), 16'd0);
    chk("mw_exit_flush", 16'(if_id_flush), 16'd1);
    chk("mw_exit_take", 16'(take_branch_addr), 16'd1);
    chk("mw_cnt", stall_cycles, 16'd3);
    nxt(); idle(); smp();
    chk("mw_flush", 16'(ctl), 16'(V_FLUSH));
    nxt(); smp();
    chk("mw_run", 16'(ctl), 16'(V_RUN));
    chk("mw_cnt_hold", stall_cycles, 16'd3);

    // Memory wait without branch exits straight to RUN (pending was cleared)
    nxt(); mem_req = 1'b1; smp();
    chk("mw2_c1", 16'(ctl), 16'(V_MEM));
    nxt(); mem_ready = 1'b1; smp();
    chk("mw2_exit", 16'(ctl), 16'(V_RUN));
    nxt(); idle(); smp();
    chk("mw2_run", 16'(ctl), 16'(V_RUN));
    chk("mw2_cnt", stall_cycles, 16'd4);

    // Asynchronous reset mid-MEM_WAIT
    nxt(); mem_req = 1'b1; smp();
    nxt(); smp();
    chk("mw3_wait", 16'(ctl), 16'(V_MEM));
    #1 nreset = 1'b0;
    #1;
    chk("async_rst_ctl", 16'(ctl), 16'(V_RST));
    chk("async_rst_cnt", stall_cycles, 16'd0);
    idle();
    nxt(); smp();
    nreset = 1'b1;
    #1;
    chk("post_rst_run", 16'(ctl), 16'(V_RUN));
    nxt(); smp();
    chk("post_rst_run2", 16'(ctl), 16'(V_RUN));
    chk("post_rst_cnt", stall_cycles, 16'd0);

    // Saturation: 70000 stalled cycles
    nxt(); mem_req = 1'b1; mem_ready = 1'b0;
    repeat (70000) @(posedge clock);
    smp();
    chk("sat_cnt", stall_cycles, 16'hFFFF);
    chk("sat_ctl", 16'(ctl), 16'(V_MEM));
    nxt(); smp();
    chk("sat_hold", stall_cycles, 16'hFFFF);
    mem_ready = 1'b1;
    nxt(); idle(); smp();
    chk("sat_after", stall_cycles, 16'hFFFF);
    chk("sat_run", 16'(ctl), 16'(V_RUN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
